fifo_burst_reader: RTL and testbench

- Read-side controller for the team's 32-deep synchronous FIFO. It drains a programmed number of words from the FIFO read port (rd_en / registered rdata / empty).
- Presents the drained words on a valid/ready output stream, marking the final word with last and pulsing done at burst completion.
- Absorbs the FIFO's 1-cycle read latency with a 2-entry output buffer, so it sustains 1 word/cycle under no backpressure.

---
 rtl/fifo_burst_reader.sv | 148 ++++++++++++++
 tb/tb_fifo_burst_reader.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for the 32-deep sync FIFO.
// Drains burst_len words onto a valid/ready stream with last/done.
module fifo_burst_reader #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_sent
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued;
  logic [LEN_W-1:0]  sent;
  logic [1:0]        occ;
  logic              inflight;
  logic [DATA_W-1:0] buf0;
  logic [DATA_W-1:0] buf1;
  logic              pop;
  logic              push;
  logic [1:0]        lvl;

  assign pop  = m_valid & m_ready;
  assign push = inflight;
  // Slots committed after this edge: buffered + in flight - leaving
  assign lvl  = occ + {1'b0, inflight} - {1'b0, pop};

  assign m_valid    = (occ != 2'd0);
  assign m_data     = buf0;
  assign m_last     = m_valid & (sent == len_q - 1'b1);
  assign words_sent = sent;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (burst_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (issued == len_q) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if ((pop && m_last) || (sent == len_q)) begin
          state_nxt = DONE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == RUN) || (state == DRAIN);
    done       = (state == DONE);
    fifo_rd_en = (state == RUN) && !fifo_empty &&
                 (issued < len_q) && (lvl < 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      issued   <= '0;
      sent     <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      if (state == IDLE && start) begin
        len_q  <= burst_len;
        issued <= '0;
        sent   <= '0;
      end else begin
        if (fifo_rd_en) begin
          issued <= issued + 1'b1;
        end
        if (pop && sent != len_q) begin
          sent <= sent + 1'b1;
        end
      end
    end
  end

  // Two-entry in-order buffer; buf0 is always the head
  always_ff @(posedge clk) begin
    if (rst) begin
      occ  <= 2'd0;
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            buf0 <= fifo_rdata;
          end else begin
            buf1 <= fifo_rdata;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            buf0 <= fifo_rdata;
          end else begin
            buf0 <= buf1;
            buf1 <= fifo_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: FIFO model, stream monitor,
// and per-scenario tasks checked against the burst rules.
module tb_fifo_burst_reader;

  localparam int DW = 32;
  localparam int LW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] burst_len = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rdata = '0;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready = 1'b0;
  logic          busy;
  logic          done;
  logic [LW-1:0] words_sent;

  fifo_burst_reader #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .burst_len  (burst_len),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_rdata (fifo_rdata),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .busy       (busy),
    .done       (done),
    .words_sent (words_sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    int            c;
  } hs_t;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  hs_t           got[$];

  int cyc = 0;
  int nrd = 0;
  int nhs = 0;
  int ndone = 0;
  int n_empty_rd = 0;
  int n_ahead = 0;
  int n_unstable = 0;
  int done_cyc = -1;

  logic          pv = 1'b0;
  logic [DW-1:0] pd = '0;
  logic          pl = 1'b0;

  // Registered-read FIFO model
  always @(posedge clk) begin
    cyc++;
    if (fifo_rd_en && fq.size() > 0) begin
      fifo_rdata <= fq.pop_front();
    end
    fifo_empty <= (fq.size() == 0);
  end

  // Stream monitor: records handshakes and protocol events
  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (fifo_rd_en) nrd++;
      if (fifo_rd_en && fifo_empty) n_empty_rd++;
      if (m_valid && m_ready) begin
        nhs++;
        got.push_back('{m_data, m_last, cyc});
      end
      if (nrd - nhs > 2) n_ahead++;
      if (pv && (!m_valid || m_data !== pd || m_last !== pl))
        n_unstable++;
      pv = m_valid && !m_ready;
      pd = m_data;
      pl = m_last;
      if (done) begin
        ndone++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    nrd = 0;
    nhs = 0;
    ndone = 0;
    n_empty_rd = 0;
    n_ahead = 0;
    n_unstable = 0;
    done_cyc = -1;
    got.delete();
    exp_q.delete();
  endtask

  task automatic flush();
    fq.delete();
    fifo_empty = 1'b1;
  endtask

  task automatic put(input logic [DW-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic pulse_start(input int len);
    burst_len = LW'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_done(input string nm, input int mode,
                                input int limit);
    int n = 0;
    int d0 = ndone;
    while (ndone == d0 && n < limit) begin
      case (mode)
        0: m_ready = 1'b1;
        1: m_ready = ~m_ready;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      tick();
      n++;
    end
    tests++;
    if (ndone == d0) begin
      fails++;
      $display("FAIL %s_timeout: no done after %0d cycles", nm, n);
    end
    m_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    tests++;
    if ({m_valid, m_last, busy, done, fifo_rd_en} !== 5'b0) begin
      fails++;
      $display("FAIL rst_ctl: got %b exp 00000",
               {m_valid, m_last, busy, done, fifo_rd_en});
    end
    tests++;
    if (m_data !== '0 || words_sent !== '0) begin
      fails++;
      $display("FAIL rst_data: got %h/%0d exp 0/0",
               m_data, words_sent);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int sc;
    clear_mon();
    for (int i = 0; i < 4; i++) put(DW'(32'hA0 + i));
    m_ready = 1'b1;
    sc = cyc;
    pulse_start(4);
    run_until_done("basic", 0, 40);
    tests++;
    if (got.size() != 4) begin
      fails++;
      $display("FAIL basic_cnt: got %0d exp 4", got.size());
    end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      tests++;
      if (got[i].d !== exp_q[i] || got[i].l !== (i == 3) ||
          got[i].c != sc + 3 + i) begin
        fails++;
        $display("FAIL basic_w%0d: got %h/%b@%0d exp %h/%b@%0d", i,
                 got[i].d, got[i].l, got[i].c - sc,
                 exp_q[i], (i == 3), 3 + i);
      end
    end
    tests++;
    if (done_cyc != sc + 7 || ndone != 1) begin
      fails++;
      $display("FAIL basic_done: got @%0d x%0d exp @7 x1",
               done_cyc - sc, ndone);
    end
    tests++;
    if (words_sent !== 6'd4 || busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_ws: got %0d/%b exp 4/0", words_sent, busy);
    end
  endtask

  task automatic test_backpressure();
    clear_mon();
    for (int i = 0; i < 8; i++) put($urandom);
    m_ready = 1'b1;
    pulse_start(8);
    run_until_done("bp", 1, 100);
    tests++;
    if (got.size() != 8) begin
      fails++;
      $display("FAIL bp_cnt: got %0d exp 8", got.size());
    end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      tests++;
      if (got[i].d !== exp_q[i] || got[i].l !== (i == 7)) begin
        fails++;
        $display("FAIL bp_w%0d: got %h/%b exp %h/%b", i,
                 got[i].d, got[i].l, exp_q[i], (i == 7));
      end
    end
    tests++;
    if (n_unstable != 0 || n_ahead != 0 || ndone != 1) begin
      fails++;
      $display("FAIL bp_proto: got unst=%0d ahead=%0d done=%0d exp 0/0/1",
               n_unstable, n_ahead, ndone);
    end
    tests++;
    if (words_sent !== 6'd8) begin
      fails++;
      $display("FAIL bp_ws: got %0d exp 8", words_sent);
    end
  endtask

  task automatic test_empty_stall();
    int lost = 0;
    clear_mon();
    put($urandom);
    put($urandom);
    m_ready = 1'b1;
    pulse_start(5);
    repeat (10) begin
      tick();
      if (!busy) lost++;
    end
    tests++;
    if (got.size() != 2 || lost != 0 || ndone != 0) begin
      fails++;
      $display("FAIL stall_hold: got n=%0d lost=%0d done=%0d exp 2/0/0",
               got.size(), lost, ndone);
    end
    for (int i = 0; i < 3; i++) put($urandom);
    run_until_done("stall", 0, 40);
    tests++;
    if (got.size() != 5) begin
      fails++;
      $display("FAIL stall_cnt: got %0d exp 5", got.size());
    end
    for (int i = 0; i < got.size() && i < 5; i++) begin
      tests++;
      if (got[i].d !== exp_q[i] || got[i].l !== (i == 4)) begin
        fails++;
        $display("FAIL stall_w%0d: got %h/%b exp %h/%b", i,
                 got[i].d, got[i].l, exp_q[i], (i == 4));
      end
    end
    tests++;
    if (n_empty_rd != 0 || ndone != 1 || words_sent !== 6'd5) begin
      fails++;
      $display("FAIL stall_end: got erd=%0d done=%0d ws=%0d exp 0/1/5",
               n_empty_rd, ndone, words_sent);
    end
  endtask

  task automatic test_zero_len();
    int sc;
    clear_mon();
    put($urandom);
    sc = cyc;
    pulse_start(0);
    run_until_done("zero", 2, 10);
    tests++;
    if (done_cyc != sc + 1 || ndone != 1) begin
      fails++;
      $display("FAIL zero_done: got @%0d x%0d exp @1 x1",
               done_cyc - sc, ndone);
    end
    tests++;
    if (nrd != 0 || got.size() != 0 || words_sent !== '0) begin
      fails++;
      $display("FAIL zero_idle: got rd=%0d hs=%0d ws=%0d exp 0/0/0",
               nrd, got.size(), words_sent);
    end
    flush();
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int d0;
    logic [DW-1:0] nxt[2];
    clear_mon();
    for (int i = 0; i < 10; i++) put($urandom);
    m_ready = 1'b1;
    pulse_start(6);
    while (nhs < 3 && n < 40) begin
      tick();
      n++;
    end
    tests++;
    if (nhs < 3) begin
      fails++;
      $display("FAIL rmid_wait: got %0d handshakes exp 3", nhs);
    end
    d0 = ndone;
    rst = 1'b1;
    m_ready = 1'b0;
    tick();
    tests++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || words_sent !== '0) begin
      fails++;
      $display("FAIL rmid_abort: got v=%b b=%b ws=%0d exp 0/0/0",
               m_valid, busy, words_sent);
    end
    rst = 1'b0;
    repeat (4) tick();
    tests++;
    if (ndone != d0) begin
      fails++;
      $display("FAIL rmid_nodone: got %0d exp %0d", ndone, d0);
    end
    nxt[0] = fq[0];
    nxt[1] = fq[1];
    clear_mon();
    m_ready = 1'b1;
    pulse_start(2);
    run_until_done("rmid", 0, 40);
    tests++;
    if (got.size() != 2) begin
      fails++;
      $display("FAIL rmid_cnt: got %0d exp 2", got.size());
    end
    for (int i = 0; i < got.size() && i < 2; i++) begin
      tests++;
      if (got[i].d !== nxt[i] || got[i].l !== (i == 1)) begin
        fails++;
        $display("FAIL rmid_w%0d: got %h/%b exp %h/%b", i,
                 got[i].d, got[i].l, nxt[i], (i == 1));
      end
    end
    flush();
  endtask

  task automatic test_start_ignored();
    clear_mon();
    for (int i = 0; i < 8; i++) put($urandom);
    m_ready = 1'b1;
    pulse_start(5);
    tick();
    burst_len = 6'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    burst_len = 6'd7;
    run_until_done("ign", 2, 100);
    tests++;
    if (got.size() != 5 || ndone != 1) begin
      fails++;
      $display("FAIL ign_cnt: got %0d/%0d exp 5/1", got.size(), ndone);
    end
    for (int i = 0; i < got.size() && i < 5; i++) begin
      tests++;
      if (got[i].d !== exp_q[i] || got[i].l !== (i == 4)) begin
        fails++;
        $display("FAIL ign_w%0d: got %h/%b exp %h/%b", i,
                 got[i].d, got[i].l, exp_q[i], (i == 4));
      end
    end
    tests++;
    if (words_sent !== 6'd5) begin
      fails++;
      $display("FAIL ign_ws: got %0d exp 5", words_sent);
    end
    flush();
  endtask

  task automatic test_random();
    int len;
    for (int it = 0; it < 4; it++) begin
      clear_mon();
      len = $urandom_range(1, 32);
      for (int i = 0; i < len + int'($urandom_range(0, 3)); i++)
        put($urandom);
      pulse_start(len);
      run_until_done("rnd", 2, 400);
      tests++;
      if (got.size() != len) begin
        fails++;
        $display("FAIL rnd%0d_cnt: got %0d exp %0d", it, got.size(), len);
      end
      for (int i = 0; i < got.size() && i < len; i++) begin
        tests++;
        if (got[i].d !== exp_q[i] || got[i].l !== (i == len - 1)) begin
          fails++;
          $display("FAIL rnd%0d_w%0d: got %h/%b exp %h/%b", it, i,
                   got[i].d, got[i].l, exp_q[i], (i == len - 1));
        end
      end
      tests++;
      if (n_ahead != 0 || n_unstable != 0 || n_empty_rd != 0 ||
          words_sent !== LW'(len)) begin
        fails++;
        $display("FAIL rnd%0d_proto: got %0d/%0d/%0d ws=%0d exp 0/0/0 ws=%0d",
                 it, n_ahead, n_unstable, n_empty_rd, words_sent, len);
      end
      flush();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_stall();
    test_zero_len();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
